// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Byte-stream to 32-bit word loader for the instruction memory;
//            holds the core in reset until the image is fully written.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          len_lo_q, len_lo_d;
    logic [ADDR_WIDTH:0] len_q, len_d;
    logic [ADDR_WIDTH:0] word_idx_q, word_idx_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [31:0]         word_q, word_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wd_q, mem_wd_d;
    logic                in_ready_q, mem_we_q, core_rst_q, busy_q, done_q, error_q;

    logic                w_xfer;
    logic [15:0]         w_len;

    assign w_xfer = in_valid & in_ready_q;
    assign w_len  = {in_data, len_lo_q};

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_d = S_LEN0;
            end
            S_LEN0: begin
                if (w_xfer) begin
                    len_lo_d = in_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (w_xfer) begin
                    if (w_len == 16'd0 || 32'(w_len) > DEPTH) begin
                        state_d = S_ERR;
                    end else begin
                        len_d      = w_len[ADDR_WIDTH:0];
                        word_idx_d = '0;
                        byte_cnt_d = '0;
                        state_d    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Write-port registers load on the 4th-byte edge so the
                    // write lands in the very next cycle.
                    if (byte_cnt_q == 2'd3) begin
                        mem_wd_d   = {in_data, word_q[23:0]};
                        mem_addr_d = 32'({word_idx_q, 2'b00});
                        state_d    = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + 1'b1;
                state_d    = (word_idx_d == len_q) ? S_DONE : S_DATA;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_lo_q   <= '0;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            core_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            // Status outputs are decoded from the next state so they are
            // glitch-free flops aligned with the state register.
            in_ready_q <= (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
            mem_we_q   <= (state_d == S_WRITE);
            core_rst_q <= (state_d == S_DONE);
            busy_q     <= (state_d == S_LEN0) || (state_d == S_LEN1) ||
                          (state_d == S_DATA) || (state_d == S_WRITE);
            done_q     <= (state_d == S_DONE);
            error_q    <= (state_d == S_ERR);
        end
    end

    assign in_ready = in_ready_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_wd   = mem_wd_q;
    assign core_rst = core_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed + randomized bench for imem_loader with a stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int AW    = 10;
    localparam int DEPTH = 2 ** AW;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, mem_we, core_rst, busy, done, error;
    logic [31:0] mem_addr, mem_wd;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .core_rst (core_rst),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } wr_t;

    int          nvec = 0;
    int          nerr = 0;
    int          cyc  = 0;
    wr_t         got[$];
    int          acc[$];
    logic [7:0]  img[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_we === 1'b1) begin
            got.push_back('{mem_addr, mem_wd, cyc});
            chk("ready_low_in_write", 32'(in_ready), 32'd0);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit gaps);
        bit accepted;
        int n;
        if (gaps) begin
            n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            for (int i = 0; i < n; i++) begin
                in_data = 8'($urandom);
                step();
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        accepted = 1'b0;
        for (int t = 0; t < 64 && !accepted; t++) begin
            accepted = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
        acc.push_back(cyc);
    endtask

    // Reference: header decides validity; each 4-byte group becomes one
    // little-endian word written at 4*index, landing on the 4th-byte cycle.
    task automatic do_load(input bit gaps);
        int          len;
        bit          good;
        logic [31:0] w;
        got.delete();
        acc.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        chk("start_err", 32'(error), 32'd0);
        chk("start_corerst", 32'(core_rst), 32'd0);
        foreach (img[i]) send(img[i], gaps);
        repeat (3) step();
        len  = int'(img[0]) + 256 * int'(img[1]);
        good = (len != 0) && (len <= DEPTH);
        chk("nwrites", 32'(got.size()), good ? 32'(len) : 32'd0);
        if (good && got.size() == len) begin
            for (int k = 0; k < len; k++) begin
                w = {img[2+4*k+3], img[2+4*k+2], img[2+4*k+1], img[2+4*k]};
                chk("wr_addr", got[k].a, 32'(4 * k));
                chk("wr_data", got[k].d, w);
                chk("wr_cycle", 32'(got[k].c), 32'(acc[2+4*k+3]));
            end
        end
        chk("end_done", 32'(done), good ? 32'd1 : 32'd0);
        chk("end_corerst", 32'(core_rst), good ? 32'd1 : 32'd0);
        chk("end_error", 32'(error), good ? 32'd0 : 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic rand_image(input int len);
        img.delete();
        img.push_back(8'(len));
        img.push_back(8'(len >> 8));
        for (int i = 0; i < 4 * len; i++) img.push_back(8'($urandom));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_corerst"}, 32'(core_rst), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        // Reset held, then released with no stimulus.
        repeat (3) step();
        check_idle("rst_held");
        rst = 1'b1;
        repeat (4) step();
        check_idle("rst_idle");
        chk("rst_nowrites", 32'(got.size()), 32'd0);

        // Two-word image, back-to-back and then with gaps.
        img = '{8'h02, 8'h00, 8'h93, 8'h82, 8'h22, 8'h00, 8'h33, 8'hE2, 8'h62, 8'h00};
        do_load(1'b0);
        if (got.size() == 2) begin
            chk("img2_w0", got[0].d, 32'h00228293);
            chk("img2_w1", got[1].d, 32'h0062E233);
        end
        do_load(1'b1);

        // Header rejections, then recovery.
        img = '{8'h00, 8'h00};
        do_load(1'b1);
        img = '{8'h01, 8'h04};
        do_load(1'b1);
        rand_image(1);
        do_load(1'b1);

        // Reset mid-word: partial word discarded, reset is asynchronous.
        got.delete();
        acc.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_idle("async_rst");
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
        chk("midword_nowrites", 32'(got.size()), 32'd0);
        check_idle("post_rst");
        rand_image(1);
        do_load(1'b0);

        // Reload from DONE.
        img = '{8'h01, 8'h00, 8'hB3, 8'h73, 8'h62, 8'h00};
        do_load(1'b1);
        if (got.size() == 1) chk("reload_w0", got[0].d, 32'h006273B3);

        // Randomized images and headers, including both length boundaries.
        for (int r = 0; r < 4; r++) begin
            rand_image(int'($urandom_range(1, 6)));
            do_load(1'b1);
        end
        img = '{8'h00, 8'h00};
        img[0] = 8'($urandom);
        img[1] = 8'($urandom_range(5, 255));
        do_load(1'b1);
        rand_image(DEPTH);
        do_load(1'b0);
        if (got.size() == DEPTH) chk("max_last_addr", got[DEPTH-1].a, 32'h00000FFC);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
